// File: rtl/mux_share_arb.sv
// Round-robin owner of the shared 2:1 LED mux select, with a minimum-hold anti-starvation counter.
// Latency: grant 1 cycle after req is sampled; a/b reach y and led[0] combinationally (0 cycles).
// Backpressure: none; requesters hold req high until granted, the loser simply waits.
//
// Ports:
//   clk        rising-edge system clock
//   rst        synchronous active-high reset
//   req[1:0]   level requests, [0] = A, [1] = B
//   a, b       data bits from requester A / B
//   gnt[1:0]   registered one-hot-or-zero grant, [0] = A, [1] = B
//   sel        mux select (= gnt[1])
//   y          muxed data bit, 0 when nobody owns the mux
//   led[3:0]   active-low LEDs: {~busy, ~gnt[1], ~gnt[0], ~y}
module mux_share_arb #(
  parameter int unsigned HOLD_CYC = 12_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       a,
  input  logic       b,
  output logic [1:0] gnt,
  output logic       sel,
  output logic       y,
  output logic [3:0] led
);

  localparam int unsigned CW = ($clog2(HOLD_CYC) < 1) ? 1 : $clog2(HOLD_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last;      // most recent owner: 0 = A, 1 = B
  logic          hold_done;
  logic          busy;

  // Once the owner has held for HOLD_CYC cycles a contending request may take over.
  assign hold_done = (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 2'b00;
      cnt   <= '0;
      last  <= 1'b1;        // B was "last", so A wins the first tie
    end else begin
      case (state)
        IDLE: begin
          // A wins if alone, or on a tie when B was the last owner.
          if (req[0] && (!req[1] || last)) begin
            state <= OWN_A;
            gnt   <= 2'b01;
            cnt   <= '0;
            last  <= 1'b0;
          end else if (req[1]) begin
            state <= OWN_B;
            gnt   <= 2'b10;
            cnt   <= '0;
            last  <= 1'b1;
          end
        end

        OWN_A: begin
          // Hand over directly (no idle gap) on release-with-waiter or on preemption.
          if (req[1] && (!req[0] || hold_done)) begin
            state <= OWN_B;
            gnt   <= 2'b10;
            cnt   <= '0;
            last  <= 1'b1;
          end else if (!req[0]) begin
            state <= IDLE;
            gnt   <= 2'b00;
            cnt   <= '0;
          end else if (!hold_done) begin
            cnt <= cnt + CW'(1);
          end
        end

        OWN_B: begin
          if (req[0] && (!req[1] || hold_done)) begin
            state <= OWN_A;
            gnt   <= 2'b01;
            cnt   <= '0;
            last  <= 1'b0;
          end else if (!req[1]) begin
            state <= IDLE;
            gnt   <= 2'b00;
            cnt   <= '0;
          end else if (!hold_done) begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Output decode: live data gated by the registered grant.
  assign busy = |gnt;
  assign sel  = gnt[1];
  assign y    = (gnt[0] & a) | (gnt[1] & b);
  assign led  = {~busy, ~gnt[1], ~gnt[0], ~y};

endmodule

// File: tb/tb_mux_share_arb.sv
module tb_mux_share_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b11;
  logic       a   = 1'b0;
  logic       b   = 1'b0;

  logic [1:0] gnt4, gnt1;
  logic       sel4, sel1, y4, y1;
  logic [3:0] led4, led1;

  int total = 0;
  int bad   = 0;

  // Reference model per instance: owner 0=none 1=A 2=B, last owner, cycles held so far.
  int m_own[2];
  int m_last[2];
  int m_held[2];
  int hc[2];

  mux_share_arb #(.HOLD_CYC(4)) dut4 (
    .clk(clk), .rst(rst), .req(req), .a(a), .b(b),
    .gnt(gnt4), .sel(sel4), .y(y4), .led(led4)
  );

  mux_share_arb #(.HOLD_CYC(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .a(a), .b(b),
    .gnt(gnt1), .sel(sel1), .y(y1), .led(led1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_gnt(input int own);
    return (own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00;
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < 2; i++) begin
      logic [1:0] g;
      logic       ey;
      logic [3:0] el;
      g  = exp_gnt(m_own[i]);
      ey = (m_own[i] == 1) ? a : (m_own[i] == 2) ? b : 1'b0;
      el = {~(|g), ~g[1], ~g[0], ~ey};
      chk($sformatf("%s/H%0d/gnt", tag, hc[i]), {2'b00, (i == 0) ? gnt4 : gnt1}, {2'b00, g});
      chk($sformatf("%s/H%0d/sel", tag, hc[i]), {3'b000, (i == 0) ? sel4 : sel1}, {3'b000, g[1]});
      chk($sformatf("%s/H%0d/y", tag, hc[i]), {3'b000, (i == 0) ? y4 : y1}, {3'b000, ey});
      chk($sformatf("%s/H%0d/led", tag, hc[i]), (i == 0) ? led4 : led1, el);
    end
  endtask

  // Apply the arbitration rules to the inputs seen at this clock edge.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_own[i] = 0; m_last[i] = 2; m_held[i] = 0;
      end else if (m_own[i] == 0) begin
        int win;
        win = 0;
        if (req == 2'b01) win = 1;
        else if (req == 2'b10) win = 2;
        else if (req == 2'b11) win = 3 - m_last[i];
        if (win != 0) begin
          m_own[i] = win; m_last[i] = win; m_held[i] = 1;
        end
      end else begin
        int  other;
        bit  mine, theirs;
        other  = 3 - m_own[i];
        mine   = req[m_own[i] - 1];
        theirs = req[other - 1];
        if (theirs && (!mine || m_held[i] >= hc[i])) begin
          m_own[i] = other; m_last[i] = other; m_held[i] = 1;
        end else if (!mine) begin
          m_own[i] = 0; m_held[i] = 0;
        end else if (m_held[i] < hc[i]) begin
          m_held[i]++;
        end
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  // Change inputs mid-cycle; outputs must only react through the a/b data path.
  task automatic drive(input logic r, input logic [1:0] rq, input logic aa, input logic bb,
                       input string tag);
    rst = r; req = rq; a = aa; b = bb;
    #1;
    check_all(tag);
  endtask

  initial begin
    int  n;
    logic [1:0] rq;
    hc[0] = 4; hc[1] = 1;
    for (int i = 0; i < 2; i++) begin
      m_own[i] = 0; m_last[i] = 2; m_held[i] = 0;
    end

    // Reset with both requesting, then A wins the first tie.
    tick("rst0");
    tick("rst1");
    chk("rst_gnt", {2'b00, gnt4}, 4'b0000);
    chk("rst_led", led4, 4'b1111);
    drive(1'b0, 2'b11, 1'b0, 1'b0, "rel");
    tick("rel");
    chk("first_tie_A", {2'b00, gnt4}, 4'b0001);

    // Single requester A with a toggling data bit.
    drive(1'b1, 2'b00, 1'b0, 1'b0, "r2");
    tick("r2");
    drive(1'b0, 2'b01, 1'b1, $urandom_range(0, 1), "single");
    for (int k = 0; k < 21; k++) begin
      tick("single");
      drive(1'b0, 2'b01, ~a, $urandom_range(0, 1), "single_d");
    end
    chk("single_held", {2'b00, gnt4}, 4'b0001);
    drive(1'b0, 2'b00, a, b, "drop");
    tick("drop");
    chk("drop_idle", {2'b00, gnt4}, 4'b0000);

    // Continuous contention from idle.
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 2'b11, $urandom_range(0, 1), $urandom_range(0, 1), "cont_d");
      tick("cont");
    end

    // Early release by A, then B keeps the grant its full hold time.
    drive(1'b1, 2'b11, 1'b0, 1'b0, "er_rst");
    tick("er_rst");
    drive(1'b0, 2'b11, 1'b0, 1'b1, "er");
    tick("er_a1");
    tick("er_a2");
    drive(1'b0, 2'b10, 1'b1, 1'b0, "er_rel");
    tick("er_hand");
    chk("handoff_B", {2'b00, gnt4}, 4'b0010);
    drive(1'b0, 2'b11, 1'b1, 1'b0, "er_rereq");
    for (int k = 0; k < 3; k++) tick("er_hold");
    chk("B_full_hold", {2'b00, gnt4}, 4'b0010);
    tick("er_pre");
    chk("A_preempts", {2'b00, gnt4}, 4'b0001);

    // Reset pulse while B owns.
    n = 0;
    while (gnt4 !== 2'b10 && n < 8) begin
      tick("seekB");
      n++;
    end
    chk("reach_B", {2'b00, gnt4}, 4'b0010);
    drive(1'b1, 2'b11, 1'b1, 1'b1, "mid_rst");
    tick("mid_rst");
    chk("mid_rst_idle", {2'b00, gnt4}, 4'b0000);
    drive(1'b0, 2'b11, 1'b1, 1'b1, "mid_rel");
    tick("mid_rel");
    chk("after_rst_A", {2'b00, gnt4}, 4'b0001);
    for (int k = 0; k < 6; k++) tick("mid_cnt");

    // Randomised traffic with occasional resets.
    rq = 2'b11;
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 3) == 0) rq = 2'($urandom_range(0, 3));
      drive(($urandom_range(0, 39) == 0), rq, $urandom_range(0, 1), $urandom_range(0, 1), "rnd_d");
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
